// File: rtl/beam_scan_ctrl.sv
// Beam-steering scan controller: sweeps delay_select over all directions, integrates
// |sample| per direction after a settling window, and locks onto the loudest one.
module beam_scan_ctrl #(
  parameter int NUM_DIRS       = 32,
  parameter int DATA_W         = 8,
  parameter int SETTLE_SAMPLES = 16,
  parameter int MEAS_LOG2      = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        sample_valid,
  input  logic signed [DATA_W-1:0]    sample,
  input  logic                        manual_en,
  input  logic [4:0]                  manual_sel,
  output logic [4:0]                  delay_select,
  output logic                        busy,
  output logic                        locked,
  output logic                        scan_done,
  output logic [DATA_W+MEAS_LOG2-1:0] best_energy
);

  localparam int ACC_W = DATA_W + MEAS_LOG2;
  localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [SET_W-1:0]     SET_LAST  = SET_W'(SETTLE_SAMPLES - 1);
  localparam logic [MEAS_LOG2-1:0] MEAS_LAST = '1;
  localparam logic [4:0]           DIR_LAST  = 5'(NUM_DIRS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_EVAL    = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [4:0]           dir_q, dir_d;
  logic [4:0]           best_dir_q, best_dir_d;
  logic [4:0]           sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 locked_q, locked_d;
  logic                 done_q, done_d;
  logic [ACC_W-1:0]     best_q, best_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [SET_W-1:0]     set_cnt_q, set_cnt_d;
  logic [MEAS_LOG2-1:0] meas_cnt_q, meas_cnt_d;

  logic                 better;
  logic [4:0]           best_dir_new;
  logic [ACC_W-1:0]     best_new;

  // Magnitude as unsigned so the most negative code maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_sample(input logic signed [DATA_W-1:0] s);
    logic [DATA_W-1:0] neg;
    neg = DATA_W'(~s) + DATA_W'(1);
    return s[DATA_W-1] ? neg : DATA_W'(s);
  endfunction

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    best_dir_d = best_dir_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    locked_d   = locked_q;
    done_d     = 1'b0;
    best_d     = best_q;
    acc_d      = acc_q;
    set_cnt_d  = set_cnt_q;
    meas_cnt_d = meas_cnt_q;

    // Strict compare keeps the lower index on ties; dir 0 always seeds the search.
    better       = (dir_q == 5'd0) || (acc_q > best_q);
    best_dir_new = better ? dir_q : best_dir_q;
    best_new     = better ? acc_q : best_q;

    if (manual_en) begin
      sel_d      = manual_sel;
      state_d    = S_IDLE;
      dir_d      = 5'd0;
      busy_d     = 1'b0;
      locked_d   = 1'b0;
      acc_d      = '0;
      set_cnt_d  = '0;
      meas_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOCKED: begin
          if (start) begin
            state_d   = S_SETTLE;
            dir_d     = 5'd0;
            sel_d     = 5'd0;
            busy_d    = 1'b1;
            locked_d  = 1'b0;
            acc_d     = '0;
            set_cnt_d = '0;
          end
        end
        S_SETTLE: begin
          if (sample_valid) begin
            if (set_cnt_q == SET_LAST) begin
              state_d    = S_MEASURE;
              set_cnt_d  = '0;
              meas_cnt_d = '0;
            end else begin
              set_cnt_d = set_cnt_q + SET_W'(1);
            end
          end
        end
        S_MEASURE: begin
          if (sample_valid) begin
            acc_d      = acc_q + ACC_W'(abs_sample(sample));
            meas_cnt_d = meas_cnt_q + MEAS_LOG2'(1);
            if (meas_cnt_q == MEAS_LAST) state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          best_d     = best_new;
          best_dir_d = best_dir_new;
          if (dir_q == DIR_LAST) begin
            sel_d    = best_dir_new;
            locked_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_LOCKED;
          end else begin
            dir_d     = dir_q + 5'd1;
            sel_d     = dir_q + 5'd1;
            acc_d     = '0;
            set_cnt_d = '0;
            state_d   = S_SETTLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= '0;
      best_dir_q <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      best_q     <= '0;
      acc_q      <= '0;
      set_cnt_q  <= '0;
      meas_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      best_dir_q <= best_dir_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
      best_q     <= best_d;
      acc_q      <= acc_d;
      set_cnt_q  <= set_cnt_d;
      meas_cnt_q <= meas_cnt_d;
    end
  end

  assign delay_select = sel_q;
  assign busy         = busy_q;
  assign locked       = locked_q;
  assign scan_done    = done_q;
  assign best_energy  = best_q;

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Bench for beam_scan_ctrl: per-direction sample tables drive scans, and a
// direction-energy reference model predicts the locked direction and energy.
module tb_beam_scan_ctrl;
  localparam int NUM_DIRS       = 32;
  localparam int DATA_W         = 8;
  localparam int SETTLE_SAMPLES = 16;
  localparam int MEAS_LOG2      = 6;
  localparam int MEAS_N         = 1 << MEAS_LOG2;
  localparam int PER_DIR        = SETTLE_SAMPLES + MEAS_N;
  localparam int EW             = DATA_W + MEAS_LOG2;

  logic                     clk = 1'b0;
  logic                     rst, start, sample_valid, manual_en;
  logic signed [DATA_W-1:0] sample;
  logic [4:0]               manual_sel, delay_select;
  logic                     busy, locked, scan_done;
  logic [EW-1:0]            best_energy;

  int checks = 0;
  int errors = 0;
  int smp[NUM_DIRS][PER_DIR];
  int exp_dir, exp_energy, last_energy;
  int strobes, done_cnt, done_at;

  beam_scan_ctrl #(
    .NUM_DIRS(NUM_DIRS), .DATA_W(DATA_W),
    .SETTLE_SAMPLES(SETTLE_SAMPLES), .MEAS_LOG2(MEAS_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample(sample), .manual_en(manual_en), .manual_sel(manual_sel),
    .delay_select(delay_select), .busy(busy), .locked(locked),
    .scan_done(scan_done), .best_energy(best_energy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (scan_done === 1'b1) begin
      done_cnt++;
      done_at = strobes;
    end
  endtask

  // Energy of a direction counts only the strobes after its settling window.
  function automatic void model(input int nd);
    int e;
    exp_dir = 0;
    exp_energy = 0;
    for (int d = 0; d < nd; d++) begin
      e = 0;
      for (int k = SETTLE_SAMPLES; k < PER_DIR; k++)
        e += (smp[d][k] < 0) ? -smp[d][k] : smp[d][k];
      if (d == 0 || e > exp_energy) begin
        exp_dir = d;
        exp_energy = e;
      end
    end
  endfunction

  task automatic feed(input int nd, input int extra, input bit inj);
    int total, d, k, gap;
    total = nd * PER_DIR + extra;
    strobes = 0;
    done_cnt = 0;
    done_at = -1;
    for (int n = 0; n < total; n++) begin
      d = n / PER_DIR;
      k = n % PER_DIR;
      sample_valid = 1'b1;
      sample = DATA_W'(smp[d][k]);
      strobes++;
      step();
      sample_valid = 1'b0;
      sample = DATA_W'($urandom);
      gap = int'($urandom_range(1, 2));
      for (int g = 0; g < gap; g++) begin
        if (inj && d < NUM_DIRS - 1 && $urandom_range(0, 15) == 0) start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    if (nd == NUM_DIRS && extra == 0) repeat (3) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || locked !== 1'b0 || delay_select !== 5'd0 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL start_entry busy=%b locked=%b sel=%0d done=%b, want busy=1 locked=0 sel=0 done=0",
               busy, locked, delay_select, scan_done);
    end
    checks++;
    if (best_energy !== EW'(last_energy)) begin
      errors++;
      $display("FAIL start_best_hold best_energy=%0d want %0d", best_energy, last_energy);
    end
  endtask

  task automatic test_full_scan(input string name, input bit inj);
    do_start();
    feed(NUM_DIRS, 0, inj);
    model(NUM_DIRS);
    checks++;
    if (done_cnt != 1 || done_at != NUM_DIRS * PER_DIR) begin
      errors++;
      $display("FAIL %s_done pulses=%0d at_strobe=%0d want 1 at %0d", name, done_cnt, done_at,
               NUM_DIRS * PER_DIR);
    end
    checks++;
    if (delay_select !== 5'(exp_dir)) begin
      errors++;
      $display("FAIL %s_dir delay_select=%0d want %0d", name, delay_select, exp_dir);
    end
    checks++;
    if (best_energy !== EW'(exp_energy)) begin
      errors++;
      $display("FAIL %s_energy best_energy=%0d want %0d", name, best_energy, exp_energy);
    end
    checks++;
    if (locked !== 1'b1 || busy !== 1'b0 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_status locked=%b busy=%b done=%b want 1 0 0", name, locked, busy, scan_done);
    end
    last_energy = exp_energy;
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int d = 0; d < NUM_DIRS; d++)
      for (int k = 0; k < PER_DIR; k++)
        smp[d][k] = int'($urandom_range(0, hi - lo)) + lo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (delay_select !== 5'd0 || busy !== 1'b0 || locked !== 1'b0 || scan_done !== 1'b0 ||
        best_energy !== '0) begin
      errors++;
      $display("FAIL reset_values sel=%0d busy=%b locked=%b done=%b best=%0d want all 0",
               delay_select, busy, locked, scan_done, best_energy);
    end
    rst = 1'b0;
    step();
    last_energy = 0;
    do_start();
    fill_random(-128, 127);
    feed(3, 10, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (delay_select !== 5'd0 || busy !== 1'b0 || locked !== 1'b0 || scan_done !== 1'b0 ||
        best_energy !== '0) begin
      errors++;
      $display("FAIL reset_async sel=%0d busy=%b locked=%b done=%b best=%0d want all 0",
               delay_select, busy, locked, scan_done, best_energy);
    end
    #2;
    rst = 1'b0;
    step();
    last_energy = 0;
    test_full_scan("reset_rescan", 1'b0);
  endtask

  task automatic test_basic();
    for (int d = 0; d < NUM_DIRS; d++)
      for (int k = 0; k < PER_DIR; k++)
        smp[d][k] = (d == 7) ? -40 : 10;
    test_full_scan("basic", 1'b0);
  endtask

  task automatic test_tie_abs();
    for (int d = 0; d < NUM_DIRS; d++)
      for (int k = 0; k < PER_DIR; k++)
        smp[d][k] = (d == 3 || d == 20) ? -128 : 1;
    test_full_scan("tie_abs", 1'b0);
  endtask

  task automatic test_settle_discard();
    for (int d = 0; d < NUM_DIRS; d++)
      for (int k = 0; k < PER_DIR; k++)
        smp[d][k] = (d == 5) ? ((k < SETTLE_SAMPLES) ? 127 : 0) : 1;
    test_full_scan("settle", 1'b0);
  endtask

  task automatic test_random_rescan();
    fill_random(-128, 127);
    test_full_scan("rand_wide", 1'b1);
    fill_random(-2, 2);
    test_full_scan("rand_ties", 1'b1);
  endtask

  task automatic test_override();
    logic [4:0] msel;
    do_start();
    fill_random(-60, 60);
    feed(9, 30, 1'b0);
    model(9);
    manual_en = 1'b1;
    manual_sel = 5'd22;
    step();
    checks++;
    if (delay_select !== 5'd22 || busy !== 1'b0 || locked !== 1'b0 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL override_enter sel=%0d busy=%b locked=%b done=%b want 22 0 0 0",
               delay_select, busy, locked, scan_done);
    end
    msel = 5'($urandom);
    manual_sel = msel;
    repeat (2) begin
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      step();
    end
    checks++;
    if (delay_select !== msel || busy !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL override_follow sel=%0d busy=%b pulses=%0d want %0d 0 0",
               delay_select, busy, done_cnt, msel);
    end
    manual_en = 1'b0;
    manual_sel = 5'($urandom);
    repeat (3) step();
    checks++;
    if (delay_select !== msel || busy !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL override_release sel=%0d busy=%b locked=%b want %0d 0 0",
               delay_select, busy, locked, msel);
    end
    checks++;
    if (best_energy !== EW'(exp_energy)) begin
      errors++;
      $display("FAIL override_best_kept best_energy=%0d want %0d", best_energy, exp_energy);
    end
    last_energy = exp_energy;
    fill_random(-128, 127);
    test_full_scan("after_override", 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    manual_en = 1'b0;
    manual_sel = '0;
    strobes = 0;
    done_cnt = 0;
    done_at = -1;
    test_reset();
    test_basic();
    test_tie_abs();
    test_settle_discard();
    test_random_rescan();
    test_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
